spi_mem_host: RTL

- SPI master for the on-board memory SPI slave port.
- Converts a parallel command into a framed transaction: one header byte {wr, 3'b000, addr[3:0]}, then N data bytes. During a write it shifts data out on MOSI. During a read it shifts 0x00 out and captures MISO.
- Used by the controller and by benches to drive the memory-mapped SPI peripheral.
- SPI mode 0: clock idles low, slave samples on rising edges. Select is active-high.

---
 rtl/spi_mem_pkg.sv | 30 +++
 rtl/spi_tick_gen.sv | 28 ++
 rtl/spi_mem_host.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory host: frame layout and FSM states.
package spi_mem_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned LEN_W    = 4;
    localparam int unsigned WR_BIT   = 7;
    localparam int unsigned ADDR_MSB = 3;
    localparam int unsigned BIT_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_NEXT  = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_e;

    // Header byte: {wr, 3'b000, addr}
    function automatic logic [DATA_W-1:0] make_header(input logic wr,
                                                      input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] hdr;
        hdr               = '0;
        hdr[WR_BIT]       = wr;
        hdr[ADDR_MSB:0]   = addr;
        return hdr;
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Phase timer: strobes tick_c_o on the last clk of every DIV-clk phase.
module spi_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic tick_c_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c_o = (cnt_q == CNT_W'(DIV - 1));

    // Count 0..DIV-1, restarting whenever the host changes state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (restart_i || tick_c_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_mem_host.sv
// SPI mode-0 master: frames a header byte plus 1..16 data bytes per command.
module spi_mem_host
    import spi_mem_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_take,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              spi_ss
);

    state_e             state_q, state_d;
    logic               phase_q, phase_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               hdr_q, hdr_d;
    logic               write_q, write_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               ss_q, ss_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               wr_take_q, wr_take_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;
    logic               rd_valid_q, rd_valid_d;

    logic               tick_c;
    logic               restart_c;
    logic [DATA_W-1:0]  hdr_c;

    assign hdr_c     = make_header(cmd_write, cmd_addr);
    assign restart_c = (state_d != state_q);

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign spi_ss    = ss_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign wr_take   = wr_take_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;

    spi_tick_gen #(
        .DIV       (DIV)
    ) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (restart_c),
        .tick_c_o  (tick_c)
    );

    // Next-state and next-output logic; outputs follow the state they belong to
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        rem_d      = rem_q;
        hdr_d      = hdr_q;
        write_d    = write_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        ss_d       = ss_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rd_data_d  = rd_data_q;
        wr_take_d  = 1'b0;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = S_SETUP;
                    write_d = cmd_write;
                    rem_d   = cmd_len;
                    hdr_d   = 1'b1;
                    shreg_d = hdr_c;
                    mosi_d  = hdr_c[DATA_W-1];
                    ss_d    = 1'b1;
                    sclk_d  = 1'b0;
                    phase_d = 1'b0;
                end
            end

            S_SETUP: begin
                if (tick_c) begin
                    state_d   = S_SHIFT;
                    phase_d   = 1'b0;
                    bit_cnt_d = BIT_W'(DATA_W - 1);
                end
            end

            S_SHIFT: begin
                if (tick_c) begin
                    if (!phase_q) begin
                        // Rising edge: slave data is sampled here
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                        rx_d    = {rx_q[DATA_W-2:0], spi_miso};
                    end else begin
                        // Falling edge: next bit or byte boundary
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_cnt_q != '0) begin
                            bit_cnt_d = bit_cnt_q - BIT_W'(1);
                            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
                            mosi_d    = shreg_q[DATA_W-2];
                        end else begin
                            if (!hdr_q && !write_q) begin
                                rd_data_d  = rx_q;
                                rd_valid_d = 1'b1;
                            end
                            if (hdr_q || (rem_q != '0)) begin
                                state_d = S_NEXT;
                                hdr_d   = 1'b0;
                                if (!hdr_q) begin
                                    rem_d = rem_q - LEN_W'(1);
                                end
                                if (write_q) begin
                                    shreg_d   = wr_data;
                                    mosi_d    = wr_data[DATA_W-1];
                                    wr_take_d = 1'b1;
                                end else begin
                                    shreg_d = '0;
                                    mosi_d  = 1'b0;
                                end
                            end else begin
                                state_d = S_HOLD;
                                mosi_d  = 1'b0;
                            end
                        end
                    end
                end
            end

            S_NEXT: begin
                state_d   = S_SHIFT;
                phase_d   = 1'b0;
                bit_cnt_d = BIT_W'(DATA_W - 1);
            end

            S_HOLD: begin
                if (tick_c) begin
                    state_d = S_GAP;
                    ss_d    = 1'b0;
                    phase_d = 1'b0;
                end
            end

            S_GAP: begin
                // Two tick periods of deselect
                if (tick_c) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                ss_d    = 1'b0;
                sclk_d  = 1'b0;
                phase_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            bit_cnt_q  <= '0;
            rem_q      <= '0;
            hdr_q      <= 1'b0;
            write_q    <= 1'b0;
            shreg_q    <= '0;
            rx_q       <= '0;
            ss_q       <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            wr_take_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            rem_q      <= rem_d;
            hdr_q      <= hdr_d;
            write_q    <= write_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            ss_q       <= ss_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            wr_take_q  <= wr_take_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule
